byte_pack_buf_ctrl: RTL
=======================

Name: byte_pack_buf_ctrl

Overview:
- Controller that uses a dual-port byte-enable RAM (separate byte write lanes, registered full-word read) as a circular word buffer.
- Accepts a byte stream (valid/ready) and writes each byte into its lane of the current word with a one-hot byte enable.
- Commits a word when it is full or at an end-of-unit marker, then streams committed words out with valid/ready and a per-word byte count.
- Sits between byte-oriented bitstream stages of the decoder and word-oriented consumers.

Parameters:
- DATA_WIDTH, 3: bytes per RAM word; must match the RAM instance.
- ADDR_WIDTH, 5: RAM address width; buffer depth DEPTH = 2^ADDR_WIDTH words.
- CW, derived: clog2(DATA_WIDTH+1), width of byte counts.

Ports:
- clk  in  1  single clock for controller and both RAM ports.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input byte valid.
- in_data  in  8  input byte.
- in_last  in  1  final byte of unit; closes the current word.
- in_ready  out  1  byte accepted when in_valid & in_ready.
- ram_data  out  8  RAM write byte.
- ram_wraddress  out  ADDR_WIDTH  RAM write word address.
- ram_wren  out  1  RAM write enable.
- ram_be  out  DATA_WIDTH  RAM byte enable, one-hot.
- ram_rdaddress  out  ADDR_WIDTH  RAM read address.
- ram_q  in  DATA_WIDTH*8  RAM registered read data.
- out_valid  out  1  output word valid.
- out_data  out  DATA_WIDTH*8  output word; byte k in bits [8k+7:8k].
- out_nbytes  out  CW  valid bytes in out_data, 1..DATA_WIDTH.
- out_last  out  1  word closed by in_last.
- out_ready  in  1  consumer accepts word.
- level  out  ADDR_WIDTH+1  committed words not yet popped, 0..DEPTH.

Behaviour:
- State: lane (0..DATA_WIDTH-1), wr_ptr, head, cnt (= level), out_valid register, output meta register, per-word meta store of {nbytes, last} with DEPTH entries.
- Reset: lane, wr_ptr, head and cnt = 0; out_valid, out_last and out_nbytes = 0; ram_wren = 0 and in_ready = 0 while rst is high; in_ready = 1 on the first cycle after reset.
- in_ready = (cnt != DEPTH). It does not depend on out_ready: a full buffer stays not-ready even during a pop cycle.
- Write path (combinational from handshake acc = in_valid & in_ready):
  - ram_wren = acc, ram_be = 1<<lane, ram_wraddress = wr_ptr, ram_data = in_data.
- On acc, if lane == DATA_WIDTH-1 or in_last:
  - Commit: meta[wr_ptr] <= {lane+1, in_last}; wr_ptr++ (wraps modulo DEPTH); lane <= 0.
  - Otherwise lane++.
- Read path:
  - load = (cnt > out_valid) & (!out_valid | out_ready).
  - ram_rdaddress = load ? head : head-1 (modulo DEPTH). This holds ram_q stable while the output stalls.
  - On load: out_valid <= 1; out_nbytes/out_last <= meta[head]; head++.
  - On pop (out_valid & out_ready & !load): out_valid <= 0.
- cnt: +1 on commit, -1 on pop, unchanged when both occur in the same cycle.
- out_data: lane k = ram_q lane k if k < out_nbytes, else 0. Stale lanes of partial words are never exposed.
- Latency: the word is committed at edge E; out_valid is high from edge E+1 when the buffer was previously empty. Sustained throughput is 1 word/clk.
- Partial-word lanes are not pre-cleared. Masking alone guarantees output correctness.
- A read of word W is never issued before its commit edge, so there is no same-address read/write hazard.
- Reset mid-word discards the partial word and all buffered words. RAM contents are not cleared.

Decomposition:
- Shared include: CW computation (clog2 function) and the meta field layout {last, nbytes}.
- One natural sub-module: byte_pack_meta_rf, a DEPTH x (CW+1) register file with 1 write and 1 async read port.
- The RAM itself is instantiated by the parent and connected through the ram_* ports.

Test Plan:
- DATA_WIDTH=3, ADDR_WIDTH=2; RAM model instantiated; out_ready=1. Stream 0x11..0x66 back to back -> words 0x332211 then 0x665544, nbytes 3, last 0. First out_valid 1 clk after the edge accepting 0x33.
- Preload all RAM words with 0xFFFFFF. Send 0xAA, then 0xBB with in_last -> out 0x00BBAA, nbytes 2, last 1. Next byte lands in lane 0 of the next address.
- out_ready=0; send 12 bytes -> level 4, in_ready 0, 13th byte held. Pop one word -> level 3, in_ready 1 the next cycle, byte 13 accepted.
- Random out_ready toggling over 40 bytes -> out_data stable while stalled, no loss, no duplication, in-order across address wrap 3->0.
- Reset after 2 bytes of a word, then send 0x01,0x02,0x03 -> only 0x030201 with nbytes 3 appears; level 0 immediately after reset.
- Level 2 steady state: commit and pop on the same edge -> level stays 2; repeat across 8 words, pointers wrap correctly.

Source files
------------

// File: rtl/byte_pack_buf_ctrl_pkg.sv
// Shared sizing helpers for the byte-pack buffer controller.
// Meta word layout is {last, nbytes}, with last at bit position CW.
package byte_pack_buf_ctrl_pkg;

  // Width of a byte count in 0..dw.
  function automatic int unsigned cw_of(input int unsigned dw);
    return $clog2(dw + 1);
  endfunction

  // Width of a lane index in 0..dw-1, never zero.
  function automatic int unsigned lane_w_of(input int unsigned dw);
    return (dw > 1) ? $clog2(dw) : 1;
  endfunction

endpackage

// File: rtl/byte_pack_buf_ctrl_if.sv
// Byte-in, word-out and RAM-side signals of the byte-pack buffer controller.
interface byte_pack_buf_ctrl_if
  import byte_pack_buf_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 3,
  parameter int unsigned ADDR_WIDTH = 5
);
  localparam int unsigned CW = cw_of(DATA_WIDTH);

  logic                    in_valid;
  logic [7:0]              in_data;
  logic                    in_last;
  logic                    in_ready;
  logic [7:0]              ram_data;
  logic [ADDR_WIDTH-1:0]   ram_wraddress;
  logic                    ram_wren;
  logic [DATA_WIDTH-1:0]   ram_be;
  logic [ADDR_WIDTH-1:0]   ram_rdaddress;
  logic [DATA_WIDTH*8-1:0] ram_q;
  logic                    out_valid;
  logic [DATA_WIDTH*8-1:0] out_data;
  logic [CW-1:0]           out_nbytes;
  logic                    out_last;
  logic                    out_ready;
  logic [ADDR_WIDTH:0]     level;

  modport master (
    input  in_valid, in_data, in_last, ram_q, out_ready,
    output in_ready, ram_data, ram_wraddress, ram_wren, ram_be, ram_rdaddress,
           out_valid, out_data, out_nbytes, out_last, level
  );

  modport slave (
    output in_valid, in_data, in_last, ram_q, out_ready,
    input  in_ready, ram_data, ram_wraddress, ram_wren, ram_be, ram_rdaddress,
           out_valid, out_data, out_nbytes, out_last, level
  );
endinterface

// File: rtl/byte_pack_buf_ctrl_meta_rf.sv
// Per-word {last, nbytes} store: one write port, one asynchronous read port.
module byte_pack_meta_rf
  import byte_pack_buf_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 3,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                       clk,
  input  logic                       we,
  input  logic [ADDR_WIDTH-1:0]      waddr,
  input  logic [cw_of(DATA_WIDTH):0] wdata,
  input  logic [ADDR_WIDTH-1:0]      raddr,
  output logic [cw_of(DATA_WIDTH):0] rdata
);
  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam int unsigned MW    = cw_of(DATA_WIDTH) + 1;

  logic [MW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/byte_pack_buf_ctrl.sv
// Packs a byte stream into words of an external byte-enable RAM used as a
// circular buffer, then streams committed words out with byte count and last.
module byte_pack_buf_ctrl
  import byte_pack_buf_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 3,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic clk,
  input  logic rst,
  byte_pack_buf_ctrl_if.master bus
);
  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam int unsigned CW    = cw_of(DATA_WIDTH);
  localparam int unsigned LW    = lane_w_of(DATA_WIDTH);
  localparam int unsigned MW    = CW + 1;

  logic [LW-1:0]           lane;
  logic [ADDR_WIDTH-1:0]   wr_ptr;
  logic [ADDR_WIDTH-1:0]   head;
  logic [ADDR_WIDTH:0]     cnt;
  logic                    out_valid_q;
  logic                    out_last_q;
  logic [CW-1:0]           out_nbytes_q;

  logic                    in_ready_c;
  logic                    acc;
  logic                    commit;
  logic                    load;
  logic                    handshake;
  logic [MW-1:0]           meta_wdata;
  logic [MW-1:0]           meta_rdata;
  logic [DATA_WIDTH*8-1:0] out_data_c;

  assign in_ready_c = !rst && (cnt != (ADDR_WIDTH+1)'(DEPTH));
  assign acc        = bus.in_valid && in_ready_c;
  assign commit     = acc && ((lane == LW'(DATA_WIDTH - 1)) || bus.in_last);
  assign handshake  = out_valid_q && bus.out_ready;
  // cnt includes the word held in the output register, hence the compare.
  assign load       = (cnt > (ADDR_WIDTH+1)'(out_valid_q)) && (!out_valid_q || bus.out_ready);
  assign meta_wdata = {bus.in_last, CW'(lane) + CW'(1)};

  byte_pack_meta_rf #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_meta (
    .clk   (clk),
    .we    (commit),
    .waddr (wr_ptr),
    .wdata (meta_wdata),
    .raddr (head),
    .rdata (meta_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      lane         <= '0;
      wr_ptr       <= '0;
      head         <= '0;
      cnt          <= '0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      out_nbytes_q <= '0;
    end else begin
      if (commit) begin
        wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
        lane   <= '0;
      end else if (acc) begin
        lane <= lane + LW'(1);
      end

      if (load) begin
        out_valid_q  <= 1'b1;
        out_nbytes_q <= meta_rdata[CW-1:0];
        out_last_q   <= meta_rdata[CW];
        head         <= head + ADDR_WIDTH'(1);
      end else if (handshake) begin
        out_valid_q <= 1'b0;
      end

      if (commit && !handshake)      cnt <= cnt + (ADDR_WIDTH+1)'(1);
      else if (!commit && handshake) cnt <= cnt - (ADDR_WIDTH+1)'(1);
    end
  end

  // Lanes beyond nbytes may hold stale RAM data from an earlier pass.
  always_comb begin
    out_data_c = '0;
    for (int unsigned k = 0; k < DATA_WIDTH; k++) begin
      if (CW'(k) < out_nbytes_q) out_data_c[8*k +: 8] = bus.ram_q[8*k +: 8];
    end
  end

  assign bus.in_ready      = in_ready_c;
  assign bus.ram_wren      = acc;
  assign bus.ram_be        = DATA_WIDTH'(1) << lane;
  assign bus.ram_wraddress = wr_ptr;
  assign bus.ram_data      = bus.in_data;
  // Re-addressing the current word while stalled keeps ram_q stable.
  assign bus.ram_rdaddress = load ? head : head - ADDR_WIDTH'(1);
  assign bus.out_valid     = out_valid_q;
  assign bus.out_data      = out_data_c;
  assign bus.out_nbytes    = out_nbytes_q;
  assign bus.out_last      = out_last_q;
  assign bus.level         = cnt;
endmodule
